// File: rtl/dm_sba_ctrl.sv
// rtl/dm_sba_ctrl.sv - System Bus Access engine: DMI sbcs/sbaddress0/sbdata0 to single-beat IBP.
module dm_sba_ctrl #(
  parameter int SBA_ADDR_W = 32,
  parameter int SBA_DATA_W = 64
) (
  input  logic                    clk,
  input  logic                    rst_a_n,
  input  logic                    dm_active,
  input  logic                    sbcs_wr,
  input  logic [2:0]              sbcs_access,
  input  logic                    sbcs_autoinc,
  input  logic                    sbcs_rdonaddr,
  input  logic                    sbcs_rdondata,
  input  logic [2:0]              sbcs_err_w1c,
  input  logic                    sbcs_busyerr_w1c,
  input  logic                    sbaddr_wr,
  input  logic [SBA_ADDR_W-1:0]   sbaddr_wdata,
  input  logic                    sbdata_wr,
  input  logic [SBA_DATA_W-1:0]   sbdata_wdata,
  input  logic                    sbdata_rd,
  output logic [SBA_ADDR_W-1:0]   sbaddress,
  output logic [SBA_DATA_W-1:0]   sbdata,
  output logic [2:0]              sbaccess,
  output logic                    sbautoinc,
  output logic                    sbrdonaddr,
  output logic                    sbrdondata,
  output logic                    sbbusy,
  output logic [2:0]              sberror,
  output logic                    sbbusyerror,
  output logic                    ibp_cmd_valid,
  output logic                    ibp_cmd_read,
  input  logic                    ibp_cmd_accept,
  output logic [SBA_ADDR_W-1:0]   ibp_cmd_addr,
  output logic [3:0]              ibp_cmd_space,
  output logic [3:0]              ibp_cmd_burst,
  input  logic                    ibp_rd_valid,
  input  logic                    ibp_rd_err,
  input  logic                    ibp_rd_last,
  input  logic [SBA_DATA_W-1:0]   ibp_rd_data,
  output logic                    ibp_rd_accept,
  output logic                    ibp_wr_valid,
  output logic                    ibp_wr_last,
  output logic [SBA_DATA_W-1:0]   ibp_wr_data,
  output logic [SBA_DATA_W/8-1:0] ibp_wr_mask,
  input  logic                    ibp_wr_accept,
  input  logic                    ibp_wr_done,
  input  logic                    ibp_wr_err,
  output logic                    ibp_wr_resp_accept
);

  localparam int NB    = SBA_DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam logic [2:0] MAX_ACC = 3'(OFF_W);

  typedef enum logic [2:0] {S_IDLE, S_RD_CMD, S_RD_RESP, S_WR_REQ, S_WR_RESP} state_t;

  state_t                  r_state;
  logic [SBA_ADDR_W-1:0]   r_addr;
  logic [SBA_DATA_W-1:0]   r_data;
  logic [2:0]              r_access;
  logic                    r_autoinc, r_rdonaddr, r_rdondata;
  logic [2:0]              r_sberror;
  logic                    r_busyerr;
  logic                    r_cmd_valid, r_cmd_read, r_rd_accept, r_wr_valid, r_wr_resp_accept;
  logic [SBA_DATA_W-1:0]   r_wr_data;
  logic [NB-1:0]           r_wr_mask;
  logic [2:0]              r_txn_acc;
  logic [OFF_W-1:0]        r_txn_off;

  // Byte mask covering 2^acc bytes starting at lane 0.
  function automatic logic [NB-1:0] f_lane_mask(input logic [2:0] acc);
    logic [NB-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < (int'(1) << acc)) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [SBA_DATA_W-1:0] f_expand(input logic [NB-1:0] bm);
    logic [SBA_DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < NB; i++) d[i*8 +: 8] = {8{bm[i]}};
    return d;
  endfunction

  logic                  w_busy, w_blocked;
  logic                  w_sel_addr, w_sel_wdat, w_sel_rdat, w_sel_any;
  logic                  w_trig_rd, w_trig_wr, w_trig;
  logic [SBA_ADDR_W-1:0] w_trig_addr, w_align_mask, w_incr;
  logic                  w_size_bad, w_misalign;
  logic [OFF_W-1:0]      w_trig_off;
  logic [NB-1:0]         w_trig_bmask;
  logic [SBA_DATA_W-1:0] w_trig_wdata, w_rd_val;
  logic                  w_cmd_pend, w_wr_pend;
  logic                  w_unused;

  assign w_busy     = (r_state != S_IDLE);
  assign w_blocked  = r_busyerr | (r_sberror != 3'd0);
  assign w_sel_addr = sbaddr_wr & ~sbcs_wr;
  assign w_sel_wdat = sbdata_wr & ~sbcs_wr & ~sbaddr_wr;
  assign w_sel_rdat = sbdata_rd & ~sbcs_wr & ~sbaddr_wr & ~sbdata_wr;
  assign w_sel_any  = w_sel_addr | w_sel_wdat | w_sel_rdat;

  assign w_trig_rd = ~w_busy & ~w_blocked & ((w_sel_addr & r_rdonaddr) | (w_sel_rdat & r_rdondata));
  assign w_trig_wr = ~w_busy & ~w_blocked & w_sel_wdat;
  assign w_trig    = w_trig_rd | w_trig_wr;

  // A read-on-address trigger targets the address being written this cycle.
  assign w_trig_addr  = w_sel_addr ? sbaddr_wdata : r_addr;
  assign w_align_mask = (SBA_ADDR_W'(1) << r_access) - SBA_ADDR_W'(1);
  assign w_size_bad   = (r_access > MAX_ACC);
  assign w_misalign   = |(w_trig_addr & w_align_mask);
  assign w_trig_off   = w_trig_addr[OFF_W-1:0];
  assign w_trig_bmask = f_lane_mask(r_access) << w_trig_off;
  assign w_trig_wdata = (sbdata_wdata & f_expand(f_lane_mask(r_access))) << {w_trig_off, 3'b000};

  assign w_rd_val = (ibp_rd_data >> {r_txn_off, 3'b000}) & f_expand(f_lane_mask(r_txn_acc));
  assign w_incr   = SBA_ADDR_W'(1) << r_txn_acc;

  assign w_cmd_pend = r_cmd_valid & ~ibp_cmd_accept;
  assign w_wr_pend  = r_wr_valid & ~ibp_wr_accept;
  assign w_unused   = ibp_rd_last;

  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      r_state          <= S_IDLE;
      r_addr           <= '0;
      r_data           <= '0;
      r_access         <= 3'd2;
      r_autoinc        <= 1'b0;
      r_rdonaddr       <= 1'b0;
      r_rdondata       <= 1'b0;
      r_sberror        <= 3'd0;
      r_busyerr        <= 1'b0;
      r_cmd_valid      <= 1'b0;
      r_cmd_read       <= 1'b0;
      r_rd_accept      <= 1'b0;
      r_wr_valid       <= 1'b0;
      r_wr_resp_accept <= 1'b0;
      r_wr_data        <= '0;
      r_wr_mask        <= '0;
      r_txn_acc        <= 3'd0;
      r_txn_off        <= '0;
    end else if (dm_active) begin
      if (sbcs_wr) begin
        r_access   <= sbcs_access;
        r_autoinc  <= sbcs_autoinc;
        r_rdonaddr <= sbcs_rdonaddr;
        r_rdondata <= sbcs_rdondata;
        r_sberror  <= r_sberror & ~sbcs_err_w1c;
        r_busyerr  <= r_busyerr & ~sbcs_busyerr_w1c;
      end else if (w_sel_any && w_busy) begin
        r_busyerr <= 1'b1;
      end else begin
        if (w_sel_addr) r_addr <= sbaddr_wdata;
        if (w_sel_wdat) r_data <= sbdata_wdata;
      end

      if (w_trig) begin
        if (w_size_bad) begin
          r_sberror <= 3'd4;
        end else if (w_misalign) begin
          r_sberror <= 3'd3;
        end else begin
          r_txn_acc   <= r_access;
          r_txn_off   <= w_trig_off;
          r_cmd_valid <= 1'b1;
          r_cmd_read  <= w_trig_rd;
          if (w_trig_rd) begin
            r_state <= S_RD_CMD;
          end else begin
            r_state    <= S_WR_REQ;
            r_wr_valid <= 1'b1;
            r_wr_data  <= w_trig_wdata;
            r_wr_mask  <= w_trig_bmask;
          end
        end
      end

      case (r_state)
        S_RD_CMD: begin
          if (ibp_cmd_accept) begin
            r_cmd_valid <= 1'b0;
            r_cmd_read  <= 1'b0;
            r_rd_accept <= 1'b1;
            r_state     <= S_RD_RESP;
          end
        end
        S_RD_RESP: begin
          if (ibp_rd_valid) begin
            r_rd_accept <= 1'b0;
            r_state     <= S_IDLE;
            if (ibp_rd_err) begin
              r_sberror <= 3'd2;
            end else begin
              r_data <= w_rd_val;
              if (r_autoinc) r_addr <= r_addr + w_incr;
            end
          end
        end
        // Command and data channels handshake independently.
        S_WR_REQ: begin
          r_cmd_valid <= w_cmd_pend;
          r_wr_valid  <= w_wr_pend;
          if (!w_cmd_pend && !w_wr_pend) begin
            r_wr_resp_accept <= 1'b1;
            r_state          <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (ibp_wr_done) begin
            r_wr_resp_accept <= 1'b0;
            r_state          <= S_IDLE;
            if (ibp_wr_err) r_sberror <= 3'd2;
            else if (r_autoinc) r_addr <= r_addr + w_incr;
          end
        end
        default: ;
      endcase
    end
  end

  assign sbaddress          = r_addr;
  assign sbdata             = r_data;
  assign sbaccess           = r_access;
  assign sbautoinc          = r_autoinc;
  assign sbrdonaddr         = r_rdonaddr;
  assign sbrdondata         = r_rdondata;
  assign sbbusy             = w_busy;
  assign sberror            = r_sberror;
  assign sbbusyerror        = r_busyerr;
  assign ibp_cmd_valid      = r_cmd_valid;
  assign ibp_cmd_read       = r_cmd_read;
  assign ibp_cmd_addr       = r_addr;
  assign ibp_cmd_space      = 4'd0;
  assign ibp_cmd_burst      = 4'd0;
  assign ibp_rd_accept      = r_rd_accept;
  assign ibp_wr_valid       = r_wr_valid;
  assign ibp_wr_last        = r_wr_valid;
  assign ibp_wr_data        = r_wr_data;
  assign ibp_wr_mask        = r_wr_mask;
  assign ibp_wr_resp_accept = r_wr_resp_accept;

endmodule

// File: tb/tb_dm_sba_ctrl.sv
// tb/tb_dm_sba_ctrl.sv - directed self-checking bench for dm_sba_ctrl.
module tb_dm_sba_ctrl;

  logic        clk = 1'b0;
  logic        rst_a_n, dm_active;
  logic        sbcs_wr, sbcs_autoinc, sbcs_rdonaddr, sbcs_rdondata, sbcs_busyerr_w1c;
  logic [2:0]  sbcs_access, sbcs_err_w1c;
  logic        sbaddr_wr, sbdata_wr, sbdata_rd;
  logic [31:0] sbaddr_wdata;
  logic [63:0] sbdata_wdata;
  logic [31:0] sbaddress;
  logic [63:0] sbdata;
  logic [2:0]  sbaccess, sberror;
  logic        sbautoinc, sbrdonaddr, sbrdondata, sbbusy, sbbusyerror;
  logic        ibp_cmd_valid, ibp_cmd_read, ibp_cmd_accept;
  logic [31:0] ibp_cmd_addr;
  logic [3:0]  ibp_cmd_space, ibp_cmd_burst;
  logic        ibp_rd_valid, ibp_rd_err, ibp_rd_last, ibp_rd_accept;
  logic [63:0] ibp_rd_data;
  logic        ibp_wr_valid, ibp_wr_last, ibp_wr_accept, ibp_wr_done, ibp_wr_err, ibp_wr_resp_accept;
  logic [63:0] ibp_wr_data;
  logic [7:0]  ibp_wr_mask;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dm_sba_ctrl #(.SBA_ADDR_W(32), .SBA_DATA_W(64)) dut (
    .clk(clk), .rst_a_n(rst_a_n), .dm_active(dm_active),
    .sbcs_wr(sbcs_wr), .sbcs_access(sbcs_access), .sbcs_autoinc(sbcs_autoinc),
    .sbcs_rdonaddr(sbcs_rdonaddr), .sbcs_rdondata(sbcs_rdondata),
    .sbcs_err_w1c(sbcs_err_w1c), .sbcs_busyerr_w1c(sbcs_busyerr_w1c),
    .sbaddr_wr(sbaddr_wr), .sbaddr_wdata(sbaddr_wdata),
    .sbdata_wr(sbdata_wr), .sbdata_wdata(sbdata_wdata), .sbdata_rd(sbdata_rd),
    .sbaddress(sbaddress), .sbdata(sbdata), .sbaccess(sbaccess),
    .sbautoinc(sbautoinc), .sbrdonaddr(sbrdonaddr), .sbrdondata(sbrdondata),
    .sbbusy(sbbusy), .sberror(sberror), .sbbusyerror(sbbusyerror),
    .ibp_cmd_valid(ibp_cmd_valid), .ibp_cmd_read(ibp_cmd_read), .ibp_cmd_accept(ibp_cmd_accept),
    .ibp_cmd_addr(ibp_cmd_addr), .ibp_cmd_space(ibp_cmd_space), .ibp_cmd_burst(ibp_cmd_burst),
    .ibp_rd_valid(ibp_rd_valid), .ibp_rd_err(ibp_rd_err), .ibp_rd_last(ibp_rd_last),
    .ibp_rd_data(ibp_rd_data), .ibp_rd_accept(ibp_rd_accept),
    .ibp_wr_valid(ibp_wr_valid), .ibp_wr_last(ibp_wr_last), .ibp_wr_data(ibp_wr_data),
    .ibp_wr_mask(ibp_wr_mask), .ibp_wr_accept(ibp_wr_accept),
    .ibp_wr_done(ibp_wr_done), .ibp_wr_err(ibp_wr_err), .ibp_wr_resp_accept(ibp_wr_resp_accept)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dmi_cs(input logic [2:0] acc, input logic ai, input logic ra,
                        input logic [2:0] ew, input logic bw);
    sbcs_wr = 1'b1; sbcs_access = acc; sbcs_autoinc = ai; sbcs_rdonaddr = ra;
    sbcs_rdondata = 1'b0; sbcs_err_w1c = ew; sbcs_busyerr_w1c = bw;
    tick();
    sbcs_wr = 1'b0; sbcs_err_w1c = 3'd0; sbcs_busyerr_w1c = 1'b0;
  endtask

  task automatic dmi_addr(input logic [31:0] a);
    sbaddr_wr = 1'b1; sbaddr_wdata = a;
    tick();
    sbaddr_wr = 1'b0;
  endtask

  task automatic dmi_wdata(input logic [63:0] d);
    sbdata_wr = 1'b1; sbdata_wdata = d;
    tick();
    sbdata_wr = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (sbaccess !== 3'd2) begin errors++; $display("FAIL rst_sbaccess: got %0d exp 2", sbaccess); end
    checks++; if (sbaddress !== 32'h0) begin errors++; $display("FAIL rst_sbaddress: got %0h exp 0", sbaddress); end
    checks++; if (sbdata !== 64'h0) begin errors++; $display("FAIL rst_sbdata: got %0h exp 0", sbdata); end
    checks++; if ({sbbusy, sberror, sbbusyerror} !== 5'd0) begin errors++; $display("FAIL rst_status: got %0h exp 0", {sbbusy, sberror, sbbusyerror}); end
    checks++; if ({ibp_cmd_valid, ibp_wr_valid, ibp_rd_accept, ibp_wr_resp_accept} !== 4'd0) begin errors++; $display("FAIL rst_ibp: got %0h exp 0", {ibp_cmd_valid, ibp_wr_valid, ibp_rd_accept, ibp_wr_resp_accept}); end
  endtask

  task automatic test_read();
    dmi_cs(3'd2, 1'b0, 1'b1, 3'd0, 1'b0);
    dmi_addr(32'h1004);
    checks++; if (sbbusy !== 1'b1) begin errors++; $display("FAIL rd_busy_n1: got %0b exp 1", sbbusy); end
    checks++; if ({ibp_cmd_valid, ibp_cmd_read} !== 2'b11) begin errors++; $display("FAIL rd_cmd: got %0b exp 11", {ibp_cmd_valid, ibp_cmd_read}); end
    checks++; if (ibp_cmd_addr !== 32'h1004) begin errors++; $display("FAIL rd_cmd_addr: got %0h exp 1004", ibp_cmd_addr); end
    ibp_cmd_accept = 1'b1; tick(); ibp_cmd_accept = 1'b0;
    checks++; if ({ibp_cmd_valid, ibp_rd_accept, sbbusy} !== 3'b011) begin errors++; $display("FAIL rd_resp_state: got %0b exp 011", {ibp_cmd_valid, ibp_rd_accept, sbbusy}); end
    ibp_rd_valid = 1'b1; ibp_rd_data = 64'hAABBCCDD_11223344; tick(); ibp_rd_valid = 1'b0;
    checks++; if (sbbusy !== 1'b0) begin errors++; $display("FAIL rd_busy_end: got %0b exp 0", sbbusy); end
    checks++; if (sbdata !== 64'hAABBCCDD) begin errors++; $display("FAIL rd_data: got %0h exp aabbccdd", sbdata); end
    checks++; if (sbaddress !== 32'h1004) begin errors++; $display("FAIL rd_noinc: got %0h exp 1004", sbaddress); end
  endtask

  task automatic test_write_autoinc();
    dmi_cs(3'd0, 1'b1, 1'b0, 3'd0, 1'b0);
    dmi_addr(32'h2003);
    checks++; if ({sbbusy, ibp_cmd_valid} !== 2'b00) begin errors++; $display("FAIL wr_addr_noread: got %0b exp 00", {sbbusy, ibp_cmd_valid}); end
    dmi_wdata(64'h5A);
    checks++; if ({ibp_cmd_valid, ibp_cmd_read, ibp_wr_valid, ibp_wr_last} !== 4'b1011) begin errors++; $display("FAIL wr_req: got %0b exp 1011", {ibp_cmd_valid, ibp_cmd_read, ibp_wr_valid, ibp_wr_last}); end
    checks++; if (ibp_wr_mask !== 8'h08) begin errors++; $display("FAIL wr_mask: got %0h exp 08", ibp_wr_mask); end
    checks++; if (ibp_wr_data !== 64'h5A00_0000) begin errors++; $display("FAIL wr_data: got %0h exp 5a000000", ibp_wr_data); end
    ibp_wr_accept = 1'b1; tick(); ibp_wr_accept = 1'b0;
    checks++; if ({ibp_cmd_valid, ibp_wr_valid, sbbusy} !== 3'b101) begin errors++; $display("FAIL wr_data_acc: got %0b exp 101", {ibp_cmd_valid, ibp_wr_valid, sbbusy}); end
    ibp_cmd_accept = 1'b1; tick(); ibp_cmd_accept = 1'b0;
    checks++; if ({ibp_cmd_valid, ibp_wr_resp_accept} !== 2'b01) begin errors++; $display("FAIL wr_resp_state: got %0b exp 01", {ibp_cmd_valid, ibp_wr_resp_accept}); end
    ibp_wr_done = 1'b1; tick(); ibp_wr_done = 1'b0;
    checks++; if (sbbusy !== 1'b0) begin errors++; $display("FAIL wr_busy_end: got %0b exp 0", sbbusy); end
    checks++; if (sbaddress !== 32'h2004) begin errors++; $display("FAIL wr_autoinc: got %0h exp 2004", sbaddress); end
    checks++; if (sberror !== 3'd0) begin errors++; $display("FAIL wr_err: got %0d exp 0", sberror); end
  endtask

  task automatic test_misaligned();
    dmi_cs(3'd2, 1'b0, 1'b1, 3'd0, 1'b0);
    dmi_addr(32'h1002);
    checks++; if (sberror !== 3'd3) begin errors++; $display("FAIL mis_err: got %0d exp 3", sberror); end
    checks++; if ({ibp_cmd_valid, sbbusy} !== 2'b00) begin errors++; $display("FAIL mis_nocmd: got %0b exp 00", {ibp_cmd_valid, sbbusy}); end
    dmi_cs(3'd2, 1'b0, 1'b1, 3'd7, 1'b0);
    checks++; if (sberror !== 3'd0) begin errors++; $display("FAIL mis_w1c: got %0d exp 0", sberror); end
    dmi_cs(3'd4, 1'b0, 1'b0, 3'd0, 1'b0);
    dmi_addr(32'h1000);
    dmi_wdata(64'h1);
    checks++; if ({sberror, ibp_cmd_valid} !== 4'b1000) begin errors++; $display("FAIL size_err: got %0h exp 8", {sberror, ibp_cmd_valid}); end
    dmi_cs(3'd2, 1'b0, 1'b0, 3'd7, 1'b0);
  endtask

  task automatic test_busy_error();
    dmi_cs(3'd2, 1'b0, 1'b0, 3'd0, 1'b0);
    dmi_addr(32'h3000);
    dmi_wdata(64'h1111_1111);
    ibp_wr_accept = 1'b1; sbdata_wr = 1'b1; sbdata_wdata = 64'h2222_2222;
    tick();
    ibp_wr_accept = 1'b0; sbdata_wr = 1'b0;
    checks++; if (sbbusyerror !== 1'b1) begin errors++; $display("FAIL busy_err_set: got %0b exp 1", sbbusyerror); end
    checks++; if (sbdata !== 64'h1111_1111) begin errors++; $display("FAIL busy_data_kept: got %0h exp 11111111", sbdata); end
    checks++; if (ibp_wr_data !== 64'h1111_1111 || ibp_wr_mask !== 8'h0F) begin errors++; $display("FAIL busy_wr_beat: got %0h/%0h exp 11111111/0f", ibp_wr_data, ibp_wr_mask); end
    repeat (4) tick();
    checks++; if ({ibp_cmd_valid, ibp_wr_valid} !== 2'b10) begin errors++; $display("FAIL busy_stall: got %0b exp 10", {ibp_cmd_valid, ibp_wr_valid}); end
    ibp_cmd_accept = 1'b1; tick(); ibp_cmd_accept = 1'b0;
    ibp_wr_done = 1'b1; tick(); ibp_wr_done = 1'b0;
    checks++; if (sbbusy !== 1'b0) begin errors++; $display("FAIL busy_done: got %0b exp 0", sbbusy); end
    dmi_wdata(64'h3333);
    checks++; if ({ibp_cmd_valid, sbbusy} !== 2'b00) begin errors++; $display("FAIL busy_blocked: got %0b exp 00", {ibp_cmd_valid, sbbusy}); end
    checks++; if (sbdata !== 64'h3333) begin errors++; $display("FAIL busy_blocked_wr: got %0h exp 3333", sbdata); end
    dmi_cs(3'd2, 1'b0, 1'b0, 3'd0, 1'b1);
    checks++; if (sbbusyerror !== 1'b0) begin errors++; $display("FAIL busy_w1c: got %0b exp 0", sbbusyerror); end
  endtask

  task automatic test_bus_error_wrap();
    dmi_cs(3'd2, 1'b1, 1'b1, 3'd0, 1'b0);
    dmi_addr(32'h4000);
    ibp_cmd_accept = 1'b1; tick(); ibp_cmd_accept = 1'b0;
    ibp_rd_valid = 1'b1; ibp_rd_err = 1'b1; ibp_rd_data = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    ibp_rd_valid = 1'b0; ibp_rd_err = 1'b0;
    checks++; if (sberror !== 3'd2) begin errors++; $display("FAIL buserr_code: got %0d exp 2", sberror); end
    checks++; if (sbdata !== 64'h3333) begin errors++; $display("FAIL buserr_data: got %0h exp 3333", sbdata); end
    checks++; if (sbaddress !== 32'h4000) begin errors++; $display("FAIL buserr_noinc: got %0h exp 4000", sbaddress); end
    dmi_cs(3'd2, 1'b1, 1'b1, 3'd7, 1'b0);
    dmi_addr(32'hFFFF_FFFC);
    checks++; if (ibp_cmd_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_cmd_addr: got %0h exp fffffffc", ibp_cmd_addr); end
    ibp_cmd_accept = 1'b1; tick(); ibp_cmd_accept = 1'b0;
    ibp_rd_valid = 1'b1; ibp_rd_data = 64'h12345678_87654321; tick(); ibp_rd_valid = 1'b0;
    checks++; if (sbaddress !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %0h exp 0", sbaddress); end
    checks++; if (sbdata !== 64'h1234_5678) begin errors++; $display("FAIL wrap_data: got %0h exp 12345678", sbdata); end
  endtask

  task automatic test_dm_inactive();
    dmi_cs(3'd2, 1'b0, 1'b1, 3'd0, 1'b0);
    dmi_addr(32'h6000);
    dm_active = 1'b0; ibp_cmd_accept = 1'b1;
    tick(); tick();
    checks++; if ({ibp_cmd_valid, ibp_rd_accept, sbbusy} !== 3'b101) begin errors++; $display("FAIL inact_freeze: got %0b exp 101", {ibp_cmd_valid, ibp_rd_accept, sbbusy}); end
    dm_active = 1'b1; tick(); ibp_cmd_accept = 1'b0;
    checks++; if (ibp_rd_accept !== 1'b1) begin errors++; $display("FAIL inact_resume: got %0b exp 1", ibp_rd_accept); end
    ibp_rd_valid = 1'b1; ibp_rd_data = 64'hFFEEDDCC_BBAA9988; tick(); ibp_rd_valid = 1'b0;
    checks++; if (sbdata !== 64'hBBAA_9988) begin errors++; $display("FAIL inact_data: got %0h exp bbaa9988", sbdata); end
  endtask

  task automatic test_reset_mid();
    dmi_cs(3'd1, 1'b0, 1'b0, 3'd0, 1'b0);
    dmi_addr(32'h5000);
    dmi_wdata(64'hBEEF);
    checks++; if ({ibp_cmd_valid, ibp_wr_valid} !== 2'b11) begin errors++; $display("FAIL rmid_wrreq: got %0b exp 11", {ibp_cmd_valid, ibp_wr_valid}); end
    rst_a_n = 1'b0;
    #1;
    checks++; if ({ibp_cmd_valid, ibp_wr_valid, sbbusy} !== 3'b000) begin errors++; $display("FAIL rmid_ibp: got %0b exp 000", {ibp_cmd_valid, ibp_wr_valid, sbbusy}); end
    checks++; if (sbaccess !== 3'd2 || sbaddress !== 32'h0 || sbdata !== 64'h0) begin errors++; $display("FAIL rmid_regs: got %0d/%0h/%0h exp 2/0/0", sbaccess, sbaddress, sbdata); end
    tick();
    rst_a_n = 1'b1;
    dmi_cs(3'd2, 1'b0, 1'b1, 3'd0, 1'b0);
    dmi_addr(32'h10);
    ibp_cmd_accept = 1'b1; tick(); ibp_cmd_accept = 1'b0;
    ibp_rd_valid = 1'b1; ibp_rd_data = 64'h0000_0000_CAFE_F00D; tick(); ibp_rd_valid = 1'b0;
    checks++; if (sbdata !== 64'hCAFE_F00D || sbbusy !== 1'b0) begin errors++; $display("FAIL rmid_read: got %0h/%0b exp cafef00d/0", sbdata, sbbusy); end
  endtask

  initial begin
    rst_a_n = 1'b0; dm_active = 1'b1;
    sbcs_wr = 1'b0; sbcs_access = 3'd0; sbcs_autoinc = 1'b0; sbcs_rdonaddr = 1'b0;
    sbcs_rdondata = 1'b0; sbcs_err_w1c = 3'd0; sbcs_busyerr_w1c = 1'b0;
    sbaddr_wr = 1'b0; sbaddr_wdata = '0; sbdata_wr = 1'b0; sbdata_wdata = '0; sbdata_rd = 1'b0;
    ibp_cmd_accept = 1'b0; ibp_rd_valid = 1'b0; ibp_rd_err = 1'b0; ibp_rd_last = 1'b1;
    ibp_rd_data = '0; ibp_wr_accept = 1'b0; ibp_wr_done = 1'b0; ibp_wr_err = 1'b0;
    repeat (2) tick();
    rst_a_n = 1'b1;
    tick();
    test_reset();
    test_read();
    test_write_autoinc();
    test_misaligned();
    test_busy_error();
    test_bus_error_wrap();
    test_dm_inactive();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_sba_ctrl.md
Name: dm_sba_ctrl

Overview:
- System Bus Access (SBA) engine of the debug module.
- Turns DMI-side accesses to sbcs/sbaddress0/sbdata0 into single-beat IBP read/write transactions.
- Its IBP master outputs feed the mst_* side of the debug module's registered IBP interface stage; responses come back from that stage.
- Maintains the sbbusy, sberror and sbbusyerror status defined by the RISC-V debug spec.

Parameters:
- SBA_ADDR_W, 32, system bus address width.
- SBA_DATA_W, 64, IBP data width; legal values 32 or 64. Max supported sbaccess = log2(SBA_DATA_W/8).

Ports:
- clk  in  1  clock.
- rst_a_n  in  1  asynchronous active-low reset.
- dm_active  in  1  module enable; when 0, all state holds.
- sbcs_wr  in  1  write pulse for sbcs. Fields: sbcs_access[2:0], sbcs_autoinc, sbcs_rdonaddr, sbcs_rdondata, sbcs_err_w1c[2:0], sbcs_busyerr_w1c.
- sbcs_access / sbcs_autoinc / sbcs_rdonaddr / sbcs_rdondata / sbcs_err_w1c / sbcs_busyerr_w1c  in  3/1/1/1/3/1  sbcs write data.
- sbaddr_wr  in  1  write pulse for sbaddress0.
- sbaddr_wdata  in  SBA_ADDR_W  sbaddress0 write data.
- sbdata_wr  in  1  write pulse for sbdata0.
- sbdata_wdata  in  SBA_DATA_W  sbdata0 write data.
- sbdata_rd  in  1  read pulse for sbdata0.
- sbaddress  out  SBA_ADDR_W  current sbaddress0.
- sbdata  out  SBA_DATA_W  current sbdata0.
- sbaccess  out  3  current sbaccess field.
- sbautoinc / sbrdonaddr / sbrdondata  out  1 each  current sbcs flags.
- sbbusy  out  1  transaction in progress.
- sberror  out  3  sticky error code.
- sbbusyerror  out  1  sticky busy-access error.
- ibp_cmd_valid / ibp_cmd_read  out  1  command channel.
- ibp_cmd_accept  in  1  command accept.
- ibp_cmd_addr  out  SBA_ADDR_W  command address.
- ibp_cmd_space  out  4  constant 0.
- ibp_cmd_burst  out  4  constant 0.
- ibp_rd_valid / ibp_rd_err / ibp_rd_last  in  1  read response.
- ibp_rd_data  in  SBA_DATA_W  read data.
- ibp_rd_accept  out  1  read response accept.
- ibp_wr_valid / ibp_wr_last  out  1  write data channel.
- ibp_wr_data  out  SBA_DATA_W  write data.
- ibp_wr_mask  out  SBA_DATA_W/8  write byte mask.
- ibp_wr_accept  in  1  write data accept.
- ibp_wr_done / ibp_wr_err  in  1  write response.
- ibp_wr_resp_accept  out  1  write response accept.

Behaviour:
- Reset: all outputs 0; sbaccess resets to 3'd2; FSM in IDLE.
- All registers update only when dm_active=1.
- DMI pulses are one-hot per cycle. If more than one is set, priority is sbcs_wr > sbaddr_wr > sbdata_wr > sbdata_rd; lower-priority pulses are ignored.
- sbcs_wr: loads the access and flag fields; sberror &= ~sbcs_err_w1c; sbbusyerror &= ~sbcs_busyerr_w1c. Accepted even while busy.
- Blocking conditions:
  - sbaddr_wr, sbdata_wr or sbdata_rd while sbbusy=1 sets sbbusyerror; the register is not updated and no access starts.
  - While sbbusyerror=1 or sberror!=0, no new access starts; register writes still take effect when not busy.
- Triggers (when IDLE and not blocked):
  - sbaddr_wr with sbrdonaddr=1 starts a read at the new address.
  - sbdata_wr starts a write of sbdata_wdata.
  - sbdata_rd with sbrdondata=1 starts a read; the sbdata value visible this cycle is the old value.
- Pre-checks at trigger (no IBP activity, FSM stays IDLE):
  - sbaccess > log2(SBA_DATA_W/8): sberror=4.
  - Address not aligned to 2^sbaccess: sberror=3.
- FSM states: IDLE, RD_CMD, RD_RESP, WR_REQ, WR_RESP. sbbusy = (state != IDLE), registered.
- Read path:
  - Trigger at cycle N: RD_CMD and ibp_cmd_valid=1, ibp_cmd_read=1 at N+1; held until ibp_cmd_accept, then RD_RESP.
  - RD_RESP: ibp_rd_accept=1; on ibp_rd_valid, go to IDLE.
  - If ibp_rd_err=1: sberror=2, sbdata unchanged.
  - Else sbdata = zero-extended byte lane(s) of ibp_rd_data at offset addr[log2(SBA_DATA_W/8)-1:0], width 2^sbaccess bytes.
- Write path:
  - WR_REQ asserts ibp_cmd_valid (read=0) and ibp_wr_valid/ibp_wr_last=1 concurrently. Each drops independently after its own accept. When both are accepted, go to WR_RESP.
  - ibp_wr_data: the sbdata low bytes placed at the lane offset. ibp_wr_mask = ((1<<2^sbaccess)-1) << offset.
  - WR_RESP: ibp_wr_resp_accept=1; on ibp_wr_done, go to IDLE. If ibp_wr_err=1, sberror=2.
- Auto-increment: on completion without error and sbautoinc=1, sbaddress += 2^sbaccess, wrapping modulo 2^SBA_ADDR_W.
- Ignored responses: ibp_rd_valid or ibp_wr_done outside the corresponding state is ignored.
- dm_active deasserted mid-transaction: the FSM and outputs freeze; the transaction resumes when dm_active returns to 1.
- rst_a_n asserted mid-transaction: immediate return to reset values. The downstream interface stage is reset by the same reset.

Test Plan:
- sbaccess=2, rdonaddr=1, sbaddr_wr 0x1004 (DATA_W=64), bus returns 0xAABBCCDD_11223344 -> cmd_addr=0x1004, cmd_read=1; sbdata=0xAABBCCDD; sbbusy high from N+1 until response+1.
- sbaccess=0, autoinc=1, sbaddr 0x2003, sbdata_wr 0x5A -> wr_mask=0x08, wr_data[31:24]=0x5A; sbaddress becomes 0x2004.
- Misaligned: sbaccess=2, sbaddr 0x1002 with rdonaddr=1 -> sberror=3, no cmd_valid; then sbcs_err_w1c=7 -> sberror=0.
- sbdata_wr while busy, with cmd_accept stalled 5 cycles -> sbbusyerror=1, in-flight write completes unchanged, subsequent triggers are blocked.
- Bus error: ibp_rd_err=1 -> sberror=2, sbdata unchanged, no autoincrement. Also: sbaddress=0xFFFFFFFC with sbaccess=2, autoinc=1 -> sbaddress wraps to 0.
- rst_a_n low while in WR_REQ -> all outputs 0 and sbaccess=2 immediately; after release, a new read completes normally.
